// File: rtl/sha_work_loader_pkg.sv
// Shared types and frame constants for the SHA-256 work loader.
// Optional feature macro: SHA_LOADER_CHECKSUM_EN (appends an XOR checksum byte to each frame).
package sha_work_loader_pkg;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
        logic [31:0] e;
        logic [31:0] f;
        logic [31:0] g;
        logic [31:0] h;
    } HashState;

    localparam int unsigned DATA_BYTES = 44;
    localparam int unsigned NUM_WORDS  = 11;
    localparam int unsigned IDX_W      = 6;

`ifdef SHA_LOADER_CHECKSUM_EN
    localparam int unsigned FRAME_LEN = 45;
`else
    localparam int unsigned FRAME_LEN = 44;
`endif

    typedef enum logic [1:0] {
        RX_WAIT,
        RX_BODY,
        RX_COMMIT
`ifdef SHA_LOADER_CHECKSUM_EN
        , RX_CHECK
`endif
    } rx_state_e;

endpackage

// File: rtl/sha_work_loader_assembler.sv
// Byte index counter, shadow word shift registers and inter-byte timeout for the work loader.
// Under SHA_LOADER_CHECKSUM_EN it also keeps a running XOR of the whole frame.
module sha_byte_assembler
    import sha_work_loader_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        accept_i,
    input  logic [7:0]  byte_i,
    output logic        frame_done_o,
    output logic        frame_abort_o,
    output HashState    shadow_state_o,
    output logic [31:0] shadow_w1_o,
    output logic [31:0] shadow_w2_o,
    output logic [31:0] shadow_w3_o
`ifdef SHA_LOADER_CHECKSUM_EN
    ,
    output logic        chk_ok_o
`endif
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      words_q [NUM_WORDS];
    logic [31:0]      words_d [NUM_WORDS];
    logic             in_frame;

    assign in_frame      = (idx_q != '0);
    assign frame_done_o  = accept_i && (idx_q == IDX_W'(FRAME_LEN - 1));
    assign frame_abort_o = in_frame && !accept_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        words_d = words_q;
        idx_d   = idx_q;
        cnt_d   = '0;
        if (accept_i) begin
            idx_d = frame_done_o ? '0 : idx_q + 1'b1;
            if (idx_q < IDX_W'(DATA_BYTES)) begin
                words_d[idx_q[5:2]] = {words_q[idx_q[5:2]][23:0], byte_i};
            end
        end else if (frame_abort_o) begin
            idx_d = '0;
        end else if (in_frame) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: the shadow words are reset along with the counters so a reset mid-frame leaves no stale bytes behind.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q <= '0;
            cnt_q <= '0;
            for (int i = 0; i < NUM_WORDS; i++) words_q[i] <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            words_q <= words_d;
        end
    end

    // Shadow fields include the byte being accepted this cycle, so a commit can load on the same edge.
    assign shadow_state_o = {words_d[0], words_d[1], words_d[2], words_d[3],
                             words_d[4], words_d[5], words_d[6], words_d[7]};
    assign shadow_w1_o    = words_d[8];
    assign shadow_w2_o    = words_d[9];
    assign shadow_w3_o    = words_d[10];

`ifdef SHA_LOADER_CHECKSUM_EN
    logic [7:0] xor_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            xor_q <= '0;
        end else if (accept_i) begin
            xor_q <= in_frame ? (xor_q ^ byte_i) : byte_i;
        end
    end

    // XOR over data bytes plus checksum byte is zero for an intact frame.
    assign chk_ok_o = (xor_q == 8'h00);
`endif

endmodule

// File: rtl/sha_work_loader.sv
// Assembles a mining job from a byte stream and commits it atomically to the SHA pre-pipeline.
// Optional feature macro: SHA_LOADER_CHECKSUM_EN (adds checksum byte and RX_CHECK state).
module sha_work_loader
    import sha_work_loader_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        output_valid,
    output logic        newblock_o,
    output HashState    state_out,
    output logic [31:0] w1,
    output logic [31:0] w2,
    output logic [31:0] w3,
    output logic        frame_error
);

    rx_state_e   state_q, state_d;
    logic        rx_ready_q, rx_ready_d;
    logic        active_q, newblock_q, error_q;
    HashState    state_out_q;
    logic [31:0] w1_q, w2_q, w3_q;
    logic        load, drop;

    logic        accept, frame_done, frame_abort;
    HashState    shadow_state;
    logic [31:0] shadow_w1, shadow_w2, shadow_w3;
`ifdef SHA_LOADER_CHECKSUM_EN
    logic        chk_ok;
`endif

    assign accept = rx_valid && rx_ready_q;

    sha_byte_assembler #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_assembler (
        .clk            (clk),
        .rst            (rst),
        .accept_i       (accept),
        .byte_i         (rx_data),
        .frame_done_o   (frame_done),
        .frame_abort_o  (frame_abort),
        .shadow_state_o (shadow_state),
        .shadow_w1_o    (shadow_w1),
        .shadow_w2_o    (shadow_w2),
        .shadow_w3_o    (shadow_w3)
`ifdef SHA_LOADER_CHECKSUM_EN
        ,
        .chk_ok_o       (chk_ok)
`endif
    );

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        drop    = 1'b0;
        unique case (state_q)
            RX_WAIT: if (accept) state_d = RX_BODY;
            RX_BODY: begin
                if (frame_done) begin
`ifdef SHA_LOADER_CHECKSUM_EN
                    state_d = RX_CHECK;
`else
                    state_d = RX_COMMIT;
                    load    = 1'b1;
`endif
                end else if (frame_abort) begin
                    state_d = RX_WAIT;
                    drop    = 1'b1;
                end
            end
`ifdef SHA_LOADER_CHECKSUM_EN
            RX_CHECK: begin
                if (chk_ok) begin
                    state_d = RX_COMMIT;
                    load    = 1'b1;
                end else begin
                    state_d = RX_WAIT;
                    drop    = 1'b1;
                end
            end
`endif
            RX_COMMIT: state_d = RX_WAIT;
            default:   state_d = RX_WAIT;
        endcase
        rx_ready_d = (state_d == RX_WAIT) || (state_d == RX_BODY);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RX_WAIT;
            rx_ready_q  <= 1'b1;
            active_q    <= 1'b0;
            newblock_q  <= 1'b0;
            error_q     <= 1'b0;
            state_out_q <= '0;
            w1_q        <= '0;
            w2_q        <= '0;
            w3_q        <= '0;
        end else begin
            state_q    <= state_d;
            rx_ready_q <= rx_ready_d;
            newblock_q <= load;
            error_q    <= drop;
            if (load) begin
                active_q    <= 1'b1;
                state_out_q <= shadow_state;
                w1_q        <= shadow_w1;
                w2_q        <= shadow_w2;
                w3_q        <= shadow_w3;
            end
        end
    end

    assign rx_ready     = rx_ready_q;
    assign output_valid = active_q;
    assign newblock_o   = newblock_q;
    assign frame_error  = error_q;
    assign state_out    = state_out_q;
    assign w1           = w1_q;
    assign w2           = w2_q;
    assign w3           = w3_q;

endmodule

// File: tb/tb_sha_work_loader.sv
// Scoreboard bench for sha_work_loader: stimulus queues expected commits/errors, a monitor pops and compares.
module tb_sha_work_loader;
    import sha_work_loader_pkg::*;

    localparam int TO = 16;
`ifdef SHA_LOADER_CHECKSUM_EN
    localparam int NB  = 45;
    localparam int LAT = 2;
`else
    localparam int NB  = 44;
    localparam int LAT = 1;
`endif

    typedef struct packed {
        HashState    st;
        logic [31:0] w1;
        logic [31:0] w2;
        logic [31:0] w3;
    } job_t;

    typedef struct {
        job_t job;
        int   cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready, output_valid, newblock_o, frame_error;
    HashState    state_out;
    logic [31:0] w1, w2, w3;

    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];
    int   err_q[$];
    job_t cur_job;
    logic exp_valid;
    logic prev_nb;

    sha_work_loader #(.TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .output_valid (output_valid),
        .newblock_o   (newblock_o),
        .state_out    (state_out),
        .w1           (w1),
        .w2           (w2),
        .w3           (w3),
        .frame_error  (frame_error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [383:0] act, input logic [383:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Sends the first nbytes of a job frame; a full frame queues its expected commit or error.
    task automatic send_frame(input job_t j, input int nbytes, input bit flip, output int last_cyc);
        logic [351:0] bits;
        logic [7:0]   b;
        logic [7:0]   x;
        int           w;
        bits = j;
        x    = 8'h00;
        for (int k = 0; k < nbytes; k++) begin
            if (k < 44) begin
                b = bits[351 - 8*k -: 8];
                x = x ^ b;
            end else begin
                b = x ^ {7'b0, flip};
            end
            @(negedge clk);
            rx_valid = 1'b1;
            rx_data  = b;
            w = 0;
            while (!rx_ready) begin
                @(negedge clk);
                w++;
                if (w > 100) begin
                    $display("FAIL rx_ready_wait: got 0 expected 1 within 100 cycles");
                    $fatal(1, "rx_ready stuck low");
                end
            end
            last_cyc = cyc;
            @(posedge clk);
        end
        if (nbytes == NB) begin
            if (flip) err_q.push_back(last_cyc + LAT);
            else      exp_q.push_back('{job: j, cyc: last_cyc + LAT});
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        int   ec;
        if (!rst) begin
            cur_job   = '0;
            exp_valid = 1'b0;
            prev_nb   = 1'b0;
        end else begin
            if (prev_nb) check("newblock_width", 384'(newblock_o), 384'(0));
            if (newblock_o) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_newblock", 384'(newblock_o), 384'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("commit_cycle", 384'(cyc), 384'(e.cyc));
                    check("commit_rx_ready", 384'(rx_ready), 384'(0));
                    cur_job   = e.job;
                    exp_valid = 1'b1;
                end
            end
            if (frame_error) begin
                if (err_q.size() == 0) begin
                    check("unexpected_frame_error", 384'(frame_error), 384'(0));
                end else begin
                    ec = err_q.pop_front();
                    check("error_cycle", 384'(cyc), 384'(ec));
                end
            end
            check("active_job", 384'({output_valid, state_out, w1, w2, w3}),
                  384'({exp_valid, cur_job}));
            prev_nb = newblock_o;
        end
    end

    initial begin
        job_t ja, jb, jc, jd, je;
        int   t0, t1;

        ja = '{st: '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                     32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19},
               w1: 32'h11223344, w2: 32'h5f5e1000, w3: 32'h1d00ffff};
        jb = ja;
        jb.w1 = 32'hdeadbeef;
        jb.st.h = 32'h01234567;
        jc = '{st: '{32'h00000001, 32'h00000002, 32'h00000003, 32'h00000004,
                     32'h00000005, 32'h00000006, 32'h00000007, 32'h80000008},
               w1: 32'hcafef00d, w2: 32'h12345678, w3: 32'h170d1f2a};
        jd = jc;
        jd.w2 = 32'h9abcdef0;
        je = jb;
        je.w3 = 32'hffffffff;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_outputs", 384'({output_valid, newblock_o, frame_error, state_out, w1, w2, w3}), 384'(0));
        check("reset_rx_ready", 384'(rx_ready), 384'(1));
        rst = 1'b1;
        repeat (100) @(negedge clk);
        check("idle_output_valid", 384'(output_valid), 384'(0));

        // Single job, with hand-checked fields in the commit cycle
        send_frame(ja, NB, 1'b0, t0);
        repeat (LAT - 1) @(negedge clk);
        check("job_a_newblock", 384'(newblock_o), 384'(1));
        check("job_a_valid", 384'(output_valid), 384'(1));
        check("job_a_state_a", 384'(state_out.a), 384'(32'h6a09e667));
        check("job_a_w3", 384'(w3), 384'(32'h1d00ffff));
        @(negedge clk);
        check("job_a_newblock_low", 384'(newblock_o), 384'(0));
        check("job_a_valid_hold", 384'(output_valid), 384'(1));
        repeat (5) @(negedge clk);

        // Job replace: A stays visible until B commits
        send_frame(jb, NB, 1'b0, t0);
        repeat (LAT - 1) @(negedge clk);
        check("job_b_w1", 384'(w1), 384'(32'hdeadbeef));
        repeat (3) @(negedge clk);

        // Back-to-back frames at minimum spacing
        send_frame(jc, NB, 1'b0, t0);
        send_frame(jd, NB, 1'b0, t1);
        check("b2b_spacing", 384'(t1 - t0), 384'(NB + LAT));
        repeat (5) @(negedge clk);

        // Timeout: partial frame dropped, active job kept
        send_frame(je, 10, 1'b0, t0);
        err_q.push_back(t0 + TO + 1);
        repeat (TO + 8) @(negedge clk);
        check("timeout_w2_kept", 384'(w2), 384'(32'h9abcdef0));
        send_frame(ja, NB, 1'b0, t0);
        repeat (5) @(negedge clk);

        // Reset mid-frame, then a fresh frame must land at index 0
        send_frame(jc, 20, 1'b0, t0);
        rst = 1'b0;
        #1;
        check("midreset_outputs", 384'({output_valid, newblock_o, frame_error, state_out, w1, w2, w3}), 384'(0));
        check("midreset_rx_ready", 384'(rx_ready), 384'(1));
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        send_frame(je, NB, 1'b0, t0);
        repeat (LAT - 1) @(negedge clk);
        check("post_reset_w3", 384'(w3), 384'(32'hffffffff));
        check("post_reset_state_a", 384'(state_out.a), 384'(32'h6a09e667));
        repeat (5) @(negedge clk);

`ifdef SHA_LOADER_CHECKSUM_EN
        // Corrupt checksum: error pulse, no commit, active job kept
        send_frame(jc, NB, 1'b1, t0);
        repeat (6) @(negedge clk);
        check("bad_chk_w1_kept", 384'(w1), 384'(32'hdeadbeef));
        send_frame(jd, NB, 1'b0, t0);
        repeat (5) @(negedge clk);
`endif

        repeat (5) @(negedge clk);
        check("pending_commits", 384'(exp_q.size()), 384'(0));
        check("pending_errors", 384'(err_q.size()), 384'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sha_work_loader.md
# sha_work_loader

Byte-stream work loader for the super-pipelined SHA-256 core. It assembles a mining job from an 8-bit receive stream: a 32-byte midstate followed by three 32-bit message words (merkle tail, timestamp, difficulty bits). It holds the job in a shadow buffer, then commits it atomically to the pre-pipeline inputs. It marks each new job with a one-cycle `newblock_o` pulse, which restarts the nonce counters downstream.

## Interface

Parameters:
- `TIMEOUT_CYCLES`, default 1000000: idle cycles tolerated between bytes of a partial frame before it is discarded.

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  reset, asynchronous, active-low
- `rx_valid`  in  1  receive byte valid
- `rx_data`  in  8  receive byte
- `rx_ready`  out  1  loader can accept a byte; transfer occurs on `rx_valid & rx_ready`
- `output_valid`  out  1  drives pre-pipeline `input_valid`
- `newblock_o`  out  1  one-cycle new-job pulse to pre-pipeline `newblock_i`
- `state_out`  out  HashState  midstate a..h to pre-pipeline `state_in`
- `w1`  out  32  last 32 bits of merkle root
- `w2`  out  32  timestamp
- `w3`  out  32  difficulty target
- `frame_error`  out  1  one-cycle pulse when a partial or corrupt frame is dropped

## Operation

- Frame format: 44 bytes, big-endian words, in this order:
  - bytes 0–31: midstate a, b, …, h
  - bytes 32–35: w1
  - bytes 36–39: w2
  - bytes 40–43: w3
- Receive FSM:
  - RX_WAIT: byte index 0, no partial frame. First accepted byte → RX_BODY.
  - RX_BODY: each accepted byte shifts into the shadow word at index/4; index increments. The last frame byte → RX_COMMIT (or RX_CHECK under the macro).
  - RX_COMMIT: one cycle. Copies the shadow buffer into the active registers and pulses `newblock_o`. → RX_WAIT.
- `rx_ready` = 1 in RX_WAIT and RX_BODY; 0 in RX_COMMIT and RX_CHECK.
- Active flag:
  - 0 out of reset.
  - Set at the first commit; never cleared except by reset.
  - `output_valid` = active flag. Once a job is loaded, the pipeline advances one nonce per cycle continuously.
- The active job (`state_out`, `w1`–`w3`) is unchanged while a new frame is being received. It changes only in the commit cycle.
- Inter-byte timeout:
  - A counter runs in RX_BODY and clears on every accepted byte.
  - When it reaches `TIMEOUT_CYCLES`: the partial frame is discarded, `frame_error` pulses for one cycle, and the FSM goes to RX_WAIT. The active job is unaffected.
- A byte presented during RX_COMMIT is not accepted (`rx_ready` = 0); the source holds it.
- Reset mid-frame: all state clears, the partial frame is lost, and the active flag is cleared.

## Timing

- All outputs are registered. Reset values: `rx_ready` = 1; all other outputs = 0.
- Last frame byte accepted at cycle t:
  - RX_COMMIT occupies cycle t+1.
  - New `state_out`/`w1`–`w3` are visible and `newblock_o` = 1 at t+1. `newblock_o` returns to 0 at t+2.
  - `rx_ready` is 0 during t+1 and 1 again at t+2.
- `output_valid` rises at t+1 of the first commit, coincident with the first `newblock_o`.
- Timeout pulse: `frame_error` is high in the cycle after the counter reaches `TIMEOUT_CYCLES`.
- Back-to-back frames: the minimum spacing between commits is 45 cycles (44 bytes + 1 commit).

## Configuration

- `SHA_LOADER_CHECKSUM_EN` defined:
  - The frame is 45 bytes; byte 44 is the XOR of bytes 0–43.
  - After byte 44, RX_CHECK (one cycle) compares the checksum.
  - Match → RX_COMMIT.
  - Mismatch → `frame_error` pulse, shadow discarded, RX_WAIT, no `newblock_o`.
  - Commit latency becomes 2 cycles after the last byte.
- Not defined: 44-byte frame, no RX_CHECK state, no checksum logic.

## Structure

- The shared SHA package provides:
  - the `HashState` struct (a..h, 32 bits each)
  - the frame-length constant, 44 or 45 selected by the macro
  - the receive FSM state enum
- One sub-module, `sha_byte_assembler`: byte index counter, shadow shift registers and timeout counter. It outputs `frame_done`, `frame_abort` and the shadow fields.
- The parent owns the commit logic, the active registers and the active flag.

## Test plan

- Reset:
  - Hold `rst` = 0 → all outputs 0, `rx_ready` = 1.
  - Release, idle 100 cycles → `output_valid` stays 0.
- Single job:
  - Send bytes 6a 09 e6 67 … (a = 0x6a09e667), w1 = 0x11223344, w2 = 0x5f5e1000, w3 = 0x1d00ffff.
  - One cycle after the last byte: `newblock_o` = 1, `output_valid` = 1, `state_out.a` = 0x6a09e667, `w3` = 0x1d00ffff.
  - Next cycle: `newblock_o` = 0, `output_valid` = 1.
- Job replace:
  - With job A active, stream job B (w1 = 0xdeadbeef).
  - Outputs keep A's w1 through the cycle of the last B byte, then switch to 0xdeadbeef with a single `newblock_o` pulse.
- Timeout (`TIMEOUT_CYCLES` = 16):
  - Send 10 bytes, then idle 16 cycles → one `frame_error` pulse; active job unchanged.
  - A following clean 44-byte frame commits correctly.
- Reset mid-frame:
  - Assert `rst` after 20 bytes → outputs 0.
  - A fresh 44-byte frame commits with correct fields, proving the byte index restarted at 0.
- Checksum (macro defined):
  - Correct XOR → commit two cycles after byte 44.
  - Flip one bit of the checksum → `frame_error` pulse, no `newblock_o`, active outputs unchanged.
